// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the multi-read-port register bank.
package reg_bank_pkg;

  typedef enum logic {
    RB_CLEAR = 1'b0,
    RB_READY = 1'b1
  } rb_state_t;

  localparam int RB_XLEN  = 64;
  localparam int RB_NREGS = 32;

endpackage

// File: rtl/reg_bank_clr_ctrl.sv
// Post-reset clear sequencer: walks entries 1..NREGS-1 writing zero, then holds READY.
// Also flags user writes that arrive while the clear is still running (wr_drop).
module reg_bank_clr_ctrl
  import reg_bank_pkg::*;
#(
  parameter int NREGS = RB_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output rb_state_t     state,
  output logic          ready,
  output logic          wr_drop
);

  rb_state_t     state_q,   state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          ready_q,   ready_d;
  logic          wr_drop_q, wr_drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RB_CLEAR;
      clr_idx_q <= AW'(1);
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      RB_CLEAR: begin
        clr_we = 1'b1;
        // Index holds at the last entry so it never wraps back to 0.
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d = RB_READY;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      default: state_d = RB_READY;
    endcase
    ready_d   = (state_d == RB_READY);
    wr_drop_d = we && (state_q == RB_CLEAR);
  end

  assign clr_addr = clr_idx_q;
  assign state    = state_q;
  assign ready    = ready_q;
  assign wr_drop  = wr_drop_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Parametrised register bank, NRD combinational read ports, one write port, reg 0 hardwired to 0.
// Optional same-cycle write-to-read forwarding when REG_BANK_BYPASS_EN is defined.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int XLEN  = RB_XLEN,
  parameter int NREGS = RB_NREGS,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  output logic              ready,
  output logic              wr_drop
);

  rb_state_t     state;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic [XLEN-1:0] rf_q [NREGS];
  logic            user_wr;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   rd_addr;

  reg_bank_clr_ctrl #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (state),
    .ready    (ready),
    .wr_drop  (wr_drop)
  );

  assign user_wr = we && (state == RB_READY) && (waddr != '0);

  // Clear and user writes are mutually exclusive by state, clear has priority anyway.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (clr_we) begin
      rf_we    = 1'b1;
      rf_waddr = clr_addr;
    end else if (user_wr) begin
      rf_we    = 1'b1;
      rf_waddr = waddr;
      rf_wdata = wdata;
    end
  end

  // No reset on the array: the clear sequence zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  always_comb begin
    rdata   = '0;
    rd_addr = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_addr = raddr[k*AW +: AW];
      if ((state == RB_READY) && (rd_addr != '0)) begin
        rdata[k*XLEN +: XLEN] = rf_q[rd_addr];
`ifdef REG_BANK_BYPASS_EN
        if (user_wr && (rd_addr == waddr)) begin
          rdata[k*XLEN +: XLEN] = wdata;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed self-checking bench for reg_bank_mp at default sizing (64 x 32, 2 read ports).
module tb_reg_bank_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                ready;
  logic                wr_drop;

  int checks   = 0;
  int failures = 0;

  reg_bank_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk     (clk),
    .rst     (rst),
    .raddr   (raddr),
    .rdata   (rdata),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ready   (ready),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rd(input int k);
    return rdata[k*XLEN +: XLEN];
  endfunction

  task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    set_raddr(5'd7, 5'd31);
    #12;
    chk("reset_ready",   {63'd0, ready},   64'd0);
    chk("reset_wr_drop", {63'd0, wr_drop}, 64'd0);
    chk("reset_rdata0",  rd(0), 64'd0);
    chk("reset_rdata1",  rd(1), 64'd0);
    tick();
    rst = 1'b0;

    // Clear sequence: 31 edges, with a write attempt to reg 5 before edge 3.
    for (int e = 1; e <= NREGS - 1; e++) begin
      set_raddr(AW'(e), 5'd5);
      if (e == 3) begin
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 64'hAA;
        #1;
        chk("clear_write_rd_port1", rd(1), 64'd0);
      end
      chk("clear_rdata0", rd(0), 64'd0);
      tick();
      we = 1'b0;
      chk("clear_ready", {63'd0, ready}, (e == NREGS - 1) ? 64'd1 : 64'd0);
      chk("clear_wr_drop", {63'd0, wr_drop}, (e == 3) ? 64'd1 : 64'd0);
    end

    for (int a = 1; a < NREGS; a++) begin
      set_raddr(AW'(a), AW'(NREGS - a));
      #1;
      chk("post_clear_port0", rd(0), 64'd0);
      chk("post_clear_port1", rd(1), 64'd0);
    end
    set_raddr(5'd5, 5'd5);
    #1;
    chk("dropped_write_reg5", rd(0), 64'd0);

    // Register 0 stays zero.
    we = 1'b1; waddr = 5'd0; wdata = 64'hDEAD;
    set_raddr(5'd0, 5'd0);
    tick();
    we = 1'b0;
    #1;
    chk("reg0_port0", rd(0), 64'd0);
    chk("reg0_port1", rd(1), 64'd0);
    chk("reg0_wr_drop", {63'd0, wr_drop}, 64'd0);

    // Normal write, visible on both ports next cycle.
    we = 1'b1; waddr = 5'd7; wdata = 64'h1234;
    set_raddr(5'd8, 5'd8);
    tick();
    we = 1'b0;
    set_raddr(5'd7, 5'd7);
    #1;
    chk("wr7_port0", rd(0), 64'h1234);
    chk("wr7_port1", rd(1), 64'h1234);
    chk("wr7_no_drop", {63'd0, wr_drop}, 64'd0);
    set_raddr(5'd7, 5'd8);
    #1;
    chk("wr7_port1_reg8", rd(1), 64'd0);

    // Same-cycle read of the address being written.
    we = 1'b1; waddr = 5'd3; wdata = 64'h11;
    tick();
    wdata = 64'h55;
    set_raddr(5'd3, 5'd7);
    #1;
`ifdef REG_BANK_BYPASS_EN
    chk("bypass_same_cycle", rd(0), 64'h55);
`else
    chk("bypass_same_cycle", rd(0), 64'h11);
`endif
    chk("bypass_other_port", rd(1), 64'h1234);
    tick();
    we = 1'b0;
    #1;
    chk("bypass_after_edge", rd(0), 64'h55);

    // Reset in the middle of operation.
    we = 1'b1; waddr = 5'd9; wdata = 64'h99;
    set_raddr(5'd9, 5'd3);
    tick();
    we = 1'b0;
    #1;
    chk("wr9_before_reset", rd(0), 64'h99);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_reg9", rd(0), 64'd0);
    chk("midrst_reg3", rd(1), 64'd0);
    tick();
    rst = 1'b0;
    for (int e = 1; e <= NREGS - 1; e++) begin
      tick();
      chk("reclear_reg9", rd(0), 64'd0);
      chk("reclear_ready", {63'd0, ready}, (e == NREGS - 1) ? 64'd1 : 64'd0);
    end
    chk("reclear_reg3", rd(1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised multi-read-port register bank that succeeds the fixed 32×64 two-port register file in the single-cycle RISC-V datapath. It adds configurable width, depth and read-port count, and hardwires register 0 to zero. After reset it runs a sequenced clear of the array, gated by a `ready` flag, and can optionally forward a same-cycle write to the read ports. It sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- `XLEN`, 64: data width in bits.
- `NREGS`, 32: number of registers, power of two, ≥ 4. `AW = $clog2(NREGS)`.
- `NRD`, 2: number of read ports, 1..4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `raddr`  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- `rdata`  out  NRD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
- `we`  in  1  write enable (RegWrite).
- `waddr`  in  AW  write address.
- `wdata`  in  XLEN  write data.
- `ready`  out  1  high once the post-reset clear has completed.
- `wr_drop`  out  1  one-cycle pulse when a write was discarded because the clear was in progress.

## Operation
- **State machine** has two states: `CLEAR` and `READY`.
  - `rst` forces `CLEAR` and sets the clear index `clr_idx` to 1.
  - In `CLEAR`, each rising edge writes 0 to `RF[clr_idx]` and increments `clr_idx`.
  - On the edge that clears entry NREGS-1, the machine goes to `READY`. `READY` is terminal until the next `rst`.
- **Reads** are combinational from `raddr` and the array.
  - Address 0 always returns 0.
  - In `CLEAR`, every port returns 0 regardless of address.
- **Writes** take effect on the rising edge when `we=1`, the state is `READY`, and `waddr≠0`.
  - A write to address 0 is silently ignored and does not assert `wr_drop`.
  - `we=1` during `CLEAR` is discarded. `wr_drop` goes high for the following cycle.
- **Reset mid-clear or mid-operation:** the clear restarts from index 1. Array contents are not reset asynchronously; the clear sequence overwrites them.
- **Arithmetic:** `clr_idx` is AW bits wide. No wrap occurs, because the transition fires at NREGS-1.
- **Simultaneous read and write of the same address:** the result depends on the configuration macro (see Configuration).

## Timing
- Reset values: `ready=0`, `wr_drop=0`, `rdata` all zeros (the state is `CLEAR`).
- Clear latency: `ready` rises after exactly NREGS-1 rising edges following `rst` deassertion (31 edges at the defaults). Both `ready` and `wr_drop` are registered outputs.
- Read latency: 0 cycles (combinational). Write-to-read latency: 1 edge without bypass, 0 with bypass.
- `wr_drop` is asserted in the cycle after the discarded write and lasts one cycle per discarded write. Back-to-back discarded writes hold it high.

## Configuration
- Macro: `REG_BANK_BYPASS_EN`.
- **Defined:** a read port whose address equals `waddr` returns `wdata` combinationally when `we=1`, the state is `READY`, and `waddr≠0`. This gives write-before-read within the same cycle.
- **Undefined:** a read port returns the stored value. The new value is visible after the edge.
- Either way, address 0 reads 0 and reads return 0 during `CLEAR`.

## Structure
- Shared package `reg_bank_pkg` holds:
  - the state enum `rb_state_t` (`RB_CLEAR`, `RB_READY`);
  - the default constants `RB_XLEN=64` and `RB_NREGS=32`.
- Sub-module `reg_bank_clr_ctrl` contains the FSM, `clr_idx`, `ready` and `wr_drop` generation. It exposes `clr_we`, `clr_addr` and `state` to the top level.
- The top level holds the array, the write mux (clear versus user write), read muxes and the bypass logic.

## Test plan
- **Reset and clear:** assert `rst`, then release it. `ready` must be 0 for 31 edges and 1 after the 31st edge. Every `raddr` reads 0 throughout, and all entries 1..31 read 0 after `ready` is high.
- **Write during clear:** `we=1`, `waddr=5`, `wdata=0xAA` during `CLEAR`. `wr_drop` must be 1 on the next cycle. After `ready`, reg 5 must read 0.
- **Register 0 is hardwired:** in `READY`, write `0xDEAD` to address 0. Reads of address 0 return 0 and `wr_drop` stays 0.
- **Normal write and read on all ports:** write 0x1234 to reg 7. On the next cycle, all NRD ports with `raddr=7` read 0x1234 and a port with `raddr=8` reads 0.
- **Same-cycle bypass:** `we=1`, `waddr=3`, `wdata=0x55`, `raddr[0]=3`, with reg 3 previously 0x11. With `REG_BANK_BYPASS_EN`, `rdata[0]` must be 0x55 in the same cycle. Without it, `rdata[0]` is 0x11 in that cycle and 0x55 after the edge.
- **Reset mid-operation:** write 0x99 to reg 9, then pulse `rst`. `ready` drops immediately, reg 9 reads 0 during the clear, and reg 9 is 0 after 31 edges.
